fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address loaded into the PC on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_en  input  1  permits new fetches when high.
REQ-005 SHALL have port imem_addr  output  32  word address to instruction memory, equal to the current PC.
REQ-006 SHALL have port imem_inst  input  32  instruction returned combinationally by instruction memory for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_target  input  32  new PC word address when redirect_valid is high.
REQ-009 SHALL have port out_valid  output  1  head instruction available to decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts head instruction.
REQ-011 SHALL have port out_inst  output  32  head instruction word.
REQ-012 SHALL have port out_pc  output  32  word address of out_inst.

Function
REQ-013 SHALL hold a 32-bit PC register; imem_addr SHALL be driven directly from the PC (no combinational path from any input).
REQ-014 SHALL contain a 2-entry FIFO of {pc, inst} pairs with a 2-bit occupancy count (0..2).
REQ-015 pop SHALL occur on a rising edge when out_valid && out_ready.
REQ-016 push SHALL occur on a rising edge when fetch_en && !redirect_valid && (count<2 || pop); push stores {PC, imem_inst} and sets PC <= PC+1.
REQ-017 PC increment SHALL wrap modulo 2^32 (32'hFFFFFFFF -> 0).
REQ-018 push and pop in the same cycle SHALL leave count unchanged; FIFO order SHALL be strictly preserved.
REQ-019 When fetch_en is low or the FIFO is full without a pop, PC and FIFO contents SHALL hold.
REQ-020 redirect_valid SHALL take priority over everything: on that edge, count <= 0, PC <= redirect_target, no push, and any concurrent pop is discarded.
REQ-021 After a redirect, the first pushed entry SHALL carry pc == redirect_target on the next edge with fetch_en high.
REQ-022 out_valid SHALL equal (count != 0); out_inst/out_pc SHALL come from the head entry.
REQ-023 While out_valid && !out_ready, out_inst and out_pc SHALL remain stable.
REQ-024 When out_valid is low, out_inst and out_pc SHALL be 32'd0.
REQ-025 Fetch latency SHALL be one cycle: an instruction pushed on edge N is visible on out_* immediately after edge N when the FIFO was empty.
REQ-026 With fetch_en and out_ready held high and no redirect, one instruction SHALL be delivered per cycle with no bubbles.

Reset
REQ-027 While rst_n is low, PC SHALL equal RESET_PC, count SHALL be 0, out_valid 0, out_inst 0, out_pc 0, immediately and independent of clk.
REQ-028 Assertion of rst_n mid-operation SHALL discard all FIFO entries and any pending redirect; the first edge after deassertion SHALL behave as the first edge after power-up.

Verification
REQ-029 Reset release, fetch_en=1, out_ready=1, memory model returns 32'h10005555 at addr 0, 32'h0c00aaaa at addr 1 -> after edge 1: out_pc=0, out_inst=32'h10005555; after edge 2: out_pc=1, out_inst=32'h0c00aaaa; imem_addr=2.
REQ-030 Backpressure: out_ready=0 from reset -> after edge 2, count=2, imem_addr=2, out_pc=0 held; edge 3 adds nothing; raising out_ready gives pc 0,1,2 in order with no loss or duplication.
REQ-031 Redirect with FIFO full: redirect_valid=1, target=32'h40, out_ready=1 -> after edge out_valid=0, imem_addr=32'h40; next edge out_pc=32'h40.
REQ-032 Wrap: redirect target 32'hFFFFFFFF, free-running -> out_pc sequence 32'hFFFFFFFF, 0, 1.
REQ-033 fetch_en=0 for 3 cycles with out_ready=1 -> FIFO drains to out_valid=0, imem_addr constant; re-enable resumes at held PC.
REQ-034 Async reset asserted between edges with count=2 -> out_valid drops to 0 before next edge; after release, first out_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register feeding a 2-entry {pc, inst} FIFO toward decode.
// Latency: one cycle from PC presentation to out_* when the FIFO is empty.
// Backpressure: out_ready low fills the FIFO, then PC holds; redirect flushes everything.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

    logic [31:0] pc;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    fetch_ent_t  fifo_q [2];
    logic        pop;
    logic        push;

    assign imem_addr = pc;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
    assign push      = fetch_en && !redirect_valid && ((count != 2'd2) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_target;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd1;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Storage is not reset; out_* are masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{pc: pc, inst: imem_inst};
        end
    end

    assign out_inst = out_valid ? fifo_q[rd_ptr].inst : 32'd0;
    assign out_pc   = out_valid ? fifo_q[rd_ptr].pc   : 32'd0;

endmodule
